// File: rtl/mems_pkg.sv
// mems_pkg: shared state encoding and DAC command word layout for the MEMS mirror SPI path
package mems_pkg;

   localparam int DAC_WIDTH = 24;

   localparam int CMD_MSB  = 23;
   localparam int CMD_LSB  = 19;
   localparam int ADDR_MSB = 18;
   localparam int ADDR_LSB = 16;
   localparam int DATA_MSB = 15;
   localparam int DATA_LSB = 0;

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, GAP} state_t;

   function automatic logic [DAC_WIDTH-1:0] dac_word(input logic [4:0] cmd, input logic [2:0] addr,
                                                     input logic [15:0] data);
      logic [DAC_WIDTH-1:0] w;
      w = '0;
      w[CMD_MSB:CMD_LSB]   = cmd;
      w[ADDR_MSB:ADDR_LSB] = addr;
      w[DATA_MSB:DATA_LSB] = data;
      return w;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCLK half-period timer giving rise/fall strobes while enabled
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic rise,
   output logic fall
);

   localparam int DW = $clog2(CLK_DIV);

   logic [DW-1:0] cnt;
   logic          phase;
   logic          tick;

   assign tick = en && (cnt == DW'(CLK_DIV - 1));
   assign rise = tick && !phase;
   assign fall = tick && phase;

   // count clk cycles per half-period; phase 0 is the low half, 1 the high half
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (tick) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mems_dac_spi_tx.sv
// mems_dac_spi_tx: MSB-first SPI transmitter for the MEMS DAC with start/busy handshake
import mems_pkg::*;

module mems_dac_spi_tx #(
   parameter int DATA_WIDTH = DAC_WIDTH,
   parameter int CLK_DIV    = 4,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2,
   parameter int CS_GAP     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mems_SPI_start,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  mems_SPI_busy,
   output logic                  spi_done,
   output logic                  dac_cs_n,
   output logic                  dac_sclk,
   output logic                  dac_mosi
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int CW = $clog2(CS_SETUP + CS_HOLD + CS_GAP + 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] sr;
   logic [BW-1:0]         bit_cnt;
   logic [CW-1:0]         cyc;
   logic                  rise;
   logic                  fall;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (state == SHIFT),
      .rise (rise),
      .fall (fall)
   );

   // frame sequencer; sr holds the bits still to follow the one on dac_mosi
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         sr            <= '0;
         bit_cnt       <= '0;
         cyc           <= '0;
         mems_SPI_busy <= 1'b0;
         spi_done      <= 1'b0;
         dac_cs_n      <= 1'b1;
         dac_sclk      <= 1'b1;
         dac_mosi      <= 1'b0;
      end else begin
         spi_done <= 1'b0;
         case (state)
            IDLE:
               if (mems_SPI_start && !spi_done) begin
                  mems_SPI_busy <= 1'b1;
                  state         <= LOAD;
               end
            LOAD: begin
               {dac_mosi, sr} <= {rom_data, 1'b0};
               dac_cs_n       <= 1'b0;
               state          <= SETUP;
            end
            SETUP:
               if (cyc == CW'(CS_SETUP - 1)) begin
                  cyc      <= '0;
                  dac_sclk <= 1'b0;
                  state    <= SHIFT;
               end else begin
                  cyc <= cyc + 1'b1;
               end
            SHIFT:
               if (rise) begin
                  dac_sclk       <= 1'b1;
                  {dac_mosi, sr} <= {sr, 1'b0};
               end else if (fall) begin
                  if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                     bit_cnt <= '0;
                     state   <= HOLD;
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     dac_sclk <= 1'b0;
                  end
               end
            HOLD:
               if (cyc == CW'(CS_HOLD - 1)) begin
                  cyc      <= '0;
                  dac_cs_n <= 1'b1;
                  dac_mosi <= 1'b0;
                  state    <= GAP;
               end else begin
                  cyc <= cyc + 1'b1;
               end
            GAP:
               if (cyc == CW'(CS_GAP - 1)) begin
                  cyc           <= '0;
                  mems_SPI_busy <= 1'b0;
                  spi_done      <= 1'b1;
                  state         <= IDLE;
               end else begin
                  cyc <= cyc + 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mems_dac_spi_tx.sv
// tb_mems_dac_spi_tx: scoreboard bench for the MEMS DAC SPI transmitter (CLK_DIV 4 and 2)
module tb_mems_dac_spi_tx;
   import mems_pkg::*;

   typedef struct {
      int          inst;
      logic [23:0] w;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start [2];
   logic [23:0] rom   [2];
   logic        busy  [2];
   logic        done  [2];
   logic        cs_n  [2];
   logic        sclk  [2];
   logic        mosi  [2];
   exp_t        q[$];
   int          vec = 0;
   int          err = 0;

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int DIV = g ? 2 : 4;
      localparam int LEN = 1 + 2 + 2 * DIV * 24 + 2 + 4;
      localparam int CSL = 2 + 2 * DIV * 24 + 2;
      localparam int SKL = DIV * 24;

      logic [23:0] bits = '0;
      int          nb   = 0;
      int          blen = 0;
      int          csl  = 0;
      int          skl  = 0;
      int          cshi = 0;
      logic        seen = 1'b0;
      logic        pd   = 1'b0;

      mems_dac_spi_tx #(.CLK_DIV(DIV)) dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .mems_SPI_start(start[g]),
         .rom_data      (rom[g]),
         .mems_SPI_busy (busy[g]),
         .spi_done      (done[g]),
         .dac_cs_n      (cs_n[g]),
         .dac_sclk      (sclk[g]),
         .dac_mosi      (mosi[g])
      );

      always @(negedge cs_n[g]) begin
         nb   = 0;
         bits = '0;
      end

      always @(negedge sclk[g]) if (!cs_n[g]) begin
         bits = {bits[22:0], mosi[g]};
         nb++;
      end

      always @(posedge cs_n[g]) if (rst_n) begin
         chk("frame_bits", nb, 24);
         chk("frame_expected", q.size() != 0, 1);
         if (q.size() != 0) begin
            chk("frame_inst", g, q[0].inst);
            chk("frame_word", bits, q[0].w);
            void'(q.pop_front());
         end
      end

      always @(negedge clk) begin
         if (!rst_n) begin
            blen = 0; csl = 0; skl = 0; cshi = 0; seen = 1'b0; pd = 1'b0;
         end else begin
            if (done[g]) chk("done_pulse", {pd, busy[g]}, 0);
            pd = done[g];
            if (busy[g]) blen++;
            else if (blen != 0) begin
               chk("busy_len", blen, LEN);
               blen = 0;
            end
            if (!cs_n[g]) begin
               if (seen && cshi != 0) chk("cs_gap_min4", cshi >= 4, 1);
               cshi = 0;
               csl++;
               if (!sclk[g]) skl++;
            end else begin
               if (csl != 0) begin
                  chk("cs_low_len", csl, CSL);
                  chk("sclk_low_len", skl, SKL);
                  csl  = 0;
                  skl  = 0;
                  seen = 1'b1;
               end
               cshi++;
            end
         end
      end
   end

   task automatic send(input int g, input logic [23:0] pre, input logic [23:0] w);
      @(negedge clk);
      start[g] = 1'b1;
      rom[g]   = pre;
      @(negedge clk);
      start[g] = 1'b0;
      rom[g]   = w;
      q.push_back('{inst: g, w: w});
      chk("busy_after_start", busy[g], 1);
      @(negedge clk);
      rom[g] = 24'($urandom);
   endtask

   task automatic wait_done(input int g);
      for (int i = 0; i < 600 && !done[g]; i++) @(negedge clk);
      chk("done_seen", done[g], 1);
   endtask

   function automatic logic [23:0] rnd_word();
      return dac_word(5'($urandom), 3'($urandom), 16'($urandom));
   endfunction

   initial begin
      int          lows;
      int          f;
      logic        ps;
      start = '{1'b0, 1'b0};
      rom   = '{24'h0, 24'h0};
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("rst_cs_n", cs_n[g], 1);
         chk("rst_sclk", sclk[g], 1);
         chk("rst_mosi", mosi[g], 0);
         chk("rst_busy", busy[g], 0);
         chk("rst_done", done[g], 0);
      end
      rst_n = 1'b1;
      send(0, 24'h0, 24'h3FA55A);
      wait_done(0);
      send(0, 24'h000001, 24'hFFFFFE);
      wait_done(0);
      send(0, rnd_word(), rnd_word());
      repeat (48) @(negedge clk);
      start[0] = 1'b1;
      rom[0]   = rnd_word();
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0);
      lows = 0;
      repeat (30) begin
         @(negedge clk);
         if (!cs_n[0]) lows++;
      end
      chk("no_second_frame", lows, 0);
      for (int k = 0; k < 5; k++) begin
         send(0, rnd_word(), rnd_word());
         wait_done(0);
      end
      send(0, rnd_word(), rnd_word());
      f  = 0;
      ps = 1'b1;
      for (int i = 0; i < 500 && f < 10; i++) begin
         @(negedge clk);
         if (ps && !sclk[0]) f++;
         ps = sclk[0];
      end
      chk("reached_bit10", f, 10);
      #2 rst_n = 1'b0;
      q.delete();
      #1;
      chk("abort_cs_n", cs_n[0], 1);
      chk("abort_sclk", sclk[0], 1);
      chk("abort_mosi", mosi[0], 0);
      chk("abort_busy", busy[0], 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_abort_idle", cs_n[0], 1);
      send(0, rnd_word(), rnd_word());
      wait_done(0);
      send(1, rnd_word(), 24'h800001);
      wait_done(1);
      for (int k = 0; k < 2; k++) begin
         send(1, rnd_word(), rnd_word());
         wait_done(1);
      end
      repeat (5) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
